// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: transmitter state encoding and framing defaults
// common to the transmitter and its 16x-oversampled receiver.
package uart_tx_ctrl_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GUARD  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the TX byte source (master) and the UART transmitter (slave).
interface uart_tx_ctrl_if
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter with nack-driven resend: start, data LSB first, parity slot,
// stop, then a guard window in which the receiver may request a resend.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int GUARD_BITS = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic           clk,
    input  logic           areset,
    input  logic           tick16,
    input  logic           par_en,
    input  logic           nack,
    uart_tx_ctrl_if.slave  src,
    output logic           txd,
    output logic           busy,
    output logic           done,
    output logic           fail
);

    localparam int SC_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BC_MAX = (DATA_BITS > GUARD_BITS) ? DATA_BITS : GUARD_BITS;
    localparam int BC_W   = $clog2(BC_MAX) + 1;
    localparam int RT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] DB_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] GB_LAST = BC_W'(GUARD_BITS - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

    tx_state_e            state_q,     state_d;
    logic [SC_W-1:0]      s_cnt_q,     s_cnt_d;
    logic [BC_W-1:0]      b_cnt_q,     b_cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] hold_q,      hold_d;
    logic                 par_en_q,    par_en_d;
    logic                 parity_q,    parity_d;
    logic [RT_W-1:0]      retry_q,     retry_d;
    logic                 nack_seen_q, nack_seen_d;
    logic                 tx_ready_q,  tx_ready_d;
    logic                 txd_q,       txd_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic                 fail_q,      fail_d;
    logic                 bit_end;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            s_cnt_q     <= '0;
            b_cnt_q     <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            par_en_q    <= 1'b0;
            parity_q    <= 1'b0;
            retry_q     <= '0;
            nack_seen_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            b_cnt_q     <= b_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            par_en_q    <= par_en_d;
            parity_q    <= parity_d;
            retry_q     <= retry_d;
            nack_seen_q <= nack_seen_d;
            tx_ready_q  <= tx_ready_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        b_cnt_d     = b_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        par_en_d    = par_en_q;
        parity_d    = parity_q;
        retry_d     = retry_q;
        nack_seen_d = nack_seen_q;
        tx_ready_d  = tx_ready_q;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        bit_end     = tick16 && (s_cnt_q == SC_LAST);

        // Bit-period counter only advances while a frame is on the line.
        if (state_q != ST_IDLE && tick16) begin
            s_cnt_d = bit_end ? '0 : s_cnt_q + SC_W'(1);
        end

        if ((state_q == ST_STOP || state_q == ST_GUARD) && nack) begin
            nack_seen_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                s_cnt_d = '0;
                b_cnt_d = '0;
                if (src.tx_valid && tx_ready_q) begin
                    hold_d      = src.tx_data;
                    shift_d     = src.tx_data;
                    par_en_d    = par_en;
                    parity_d    = ^src.tx_data;
                    retry_d     = '0;
                    nack_seen_d = 1'b0;
                    tx_ready_d  = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    b_cnt_d = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (b_cnt_q == DB_LAST) begin
                        b_cnt_d = '0;
                        state_d = ST_PARITY;
                    end else begin
                        b_cnt_d = b_cnt_q + BC_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    b_cnt_d = '0;
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (bit_end) begin
                    if (b_cnt_q == GB_LAST) begin
                        b_cnt_d = '0;
                        // A nack arriving on the final guard tick still counts.
                        if (nack_seen_d && retry_q < RT_MAX) begin
                            retry_d     = retry_q + RT_W'(1);
                            shift_d     = hold_q;
                            nack_seen_d = 1'b0;
                            state_d     = ST_START;
                        end else begin
                            fail_d     = nack_seen_d;
                            done_d     = ~nack_seen_d;
                            tx_ready_d = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        b_cnt_d = b_cnt_q + BC_W'(1);
                    end
                end
            end
            default: begin
                tx_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase

        // Line level is registered from the next state so txd never glitches.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_en_q ? parity_q : 1'b1;
            default:   txd_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign src.tx_ready = tx_ready_q;
    assign txd          = txd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame bit patterns, parity slot, nack resend,
// retry exhaustion, asynchronous abort and back-to-back handshakes.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    logic areset, tick16, par_en, nack;
    logic txd, busy, done, fail;
    bit   tick_en;
    int   tick_div = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    uart_tx_ctrl_if #(.DATA_BITS(8)) bus ();

    uart_tx_ctrl #(
        .OVERSAMPLE(16),
        .DATA_BITS (8),
        .GUARD_BITS(1),
        .MAX_RETRY (3)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .tick16(tick16),
        .par_en(par_en),
        .nack  (nack),
        .src   (bus),
        .txd   (txd),
        .busy  (busy),
        .done  (done),
        .fail  (fail)
    );

    always #5 clk = ~clk;

    // tick16 every 4th clock, updated just after the rising edge
    always @(posedge clk) begin
        #1;
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
        tick16   = tick_en && (tick_div == 0);
    end

    // Follows one frame from its start bit through the guard period (192 ticks),
    // sampling each of the 12 bit periods mid-bit. On start detection the source
    // inputs are replaced by nv/nd/npe.
    task automatic watch_frame(input bit do_nack, input logic nv, input logic [7:0] nd,
                               input logic npe, output logic [11:0] bits,
                               output int n_done, output int n_fail, output int done_tick,
                               output int wait_cyc, output bit timeout);
        int  consumed;
        int  guard;
        bit  nacked;
        bits = '1; n_done = 0; n_fail = 0; done_tick = -1; wait_cyc = 0;
        timeout = 1'b0; consumed = 0; guard = 0; nacked = 1'b0;
        while (txd !== 1'b0 && wait_cyc < 2000) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (txd !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        bus.tx_valid = nv;
        bus.tx_data  = nd;
        par_en       = npe;
        while (guard < 2000) begin
            if (done === 1'b1) begin n_done++; done_tick = consumed; end
            if (fail === 1'b1) n_fail++;
            if (nack === 1'b1) nack = 1'b0;
            for (int k = 0; k < 12; k++) if (consumed == 16 * k + 8) bits[k] = txd;
            if (do_nack && !nacked && consumed == 16 * 11 + 8) begin
                nack   = 1'b1;
                nacked = 1'b1;
            end
            if (consumed == 192) break;
            if (tick16 === 1'b1) consumed++;
            @(negedge clk);
            guard++;
        end
        if (consumed != 192) timeout = 1'b1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: txd=%b ready=%b busy=%b done=%b fail=%b, required 1 1 0 0 0",
                     txd, bus.tx_ready, busy, done, fail);
        end
        areset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: txd=%b ready=%b busy=%b, required 1 1 0", txd, bus.tx_ready, busy);
        end
    endtask

    task automatic test_basic_frame();
        logic [11:0] bits; int nd, nf, dt, wc; bit to;
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'hA5; par_en = 1'b1;
        watch_frame(1'b0, 1'b0, 8'h5A, 1'b0, bits, nd, nf, dt, wc, to);
        tests_run++;
        if (to || bits !== 12'hD4A) begin
            tests_failed++;
            $display("FAIL a5_bits: got %b timeout=%0d, required %b", bits, to, 12'hD4A);
        end
        tests_run++;
        if (nd !== 1 || nf !== 0 || dt !== 192) begin
            tests_failed++;
            $display("FAIL a5_done: done=%0d fail=%0d at tick %0d, required 1 0 at 192", nd, nf, dt);
        end
        tests_run++;
        if (bus.tx_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL a5_idle: ready=%b busy=%b, required 1 0", bus.tx_ready, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL a5_done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_parity();
        logic [11:0] bits; int nd, nf, dt, wc; bit to;
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h01; par_en = 1'b1;
        watch_frame(1'b0, 1'b0, 8'h00, 1'b0, bits, nd, nf, dt, wc, to);
        tests_run++;
        if (to || bits !== 12'hE02 || nd !== 1 || nf !== 0) begin
            tests_failed++;
            $display("FAIL par_01_even: bits=%b done=%0d fail=%0d, required %b 1 0", bits, nd, nf, 12'hE02);
        end
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h3C; par_en = 1'b0;
        watch_frame(1'b0, 1'b0, 8'h00, 1'b1, bits, nd, nf, dt, wc, to);
        tests_run++;
        if (to || bits !== 12'hE78 || nd !== 1 || nf !== 0) begin
            tests_failed++;
            $display("FAIL par_3c_off: bits=%b done=%0d fail=%0d, required %b 1 0", bits, nd, nf, 12'hE78);
        end
    endtask

    task automatic test_retry_once();
        logic [11:0] bits; int nd, nf, dt, wc; bit to;
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h5A; par_en = 1'b1;
        watch_frame(1'b1, 1'b0, 8'h00, 1'b0, bits, nd, nf, dt, wc, to);
        tests_run++;
        if (to || bits !== 12'hCB4 || nd !== 0 || nf !== 0) begin
            tests_failed++;
            $display("FAIL retry_first: bits=%b done=%0d fail=%0d, required %b 0 0", bits, nd, nf, 12'hCB4);
        end
        watch_frame(1'b0, 1'b0, 8'h00, 1'b0, bits, nd, nf, dt, wc, to);
        tests_run++;
        if (to || bits !== 12'hCB4 || wc !== 0) begin
            tests_failed++;
            $display("FAIL retry_resend: bits=%b gap=%0d, required %b gap 0", bits, wc, 12'hCB4);
        end
        tests_run++;
        if (nd !== 1 || nf !== 0) begin
            tests_failed++;
            $display("FAIL retry_done: done=%0d fail=%0d, required 1 0", nd, nf);
        end
    endtask

    task automatic test_max_retry();
        logic [11:0] bits; int nd, nf, dt, wc; bit to;
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'hC3; par_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            watch_frame(1'b1, 1'b0, 8'h00, 1'b0, bits, nd, nf, dt, wc, to);
            tests_run++;
            if (to || bits !== 12'hD86 || nd !== 0 || nf !== ((i == 3) ? 1 : 0)) begin
                tests_failed++;
                $display("FAIL maxretry_frame%0d: bits=%b done=%0d fail=%0d, required %b 0 %0d",
                         i, bits, nd, nf, 12'hD86, (i == 3) ? 1 : 0);
            end
        end
        tests_run++;
        if (bus.tx_ready !== 1'b1 || txd !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL maxretry_idle: ready=%b txd=%b busy=%b, required 1 1 0", bus.tx_ready, txd, busy);
        end
        @(negedge clk);
        tests_run++;
        if (fail !== 1'b0 || txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL maxretry_after: fail=%b txd=%b, required 0 1", fail, txd);
        end
    endtask

    task automatic test_abort();
        logic [11:0] bits; int nd, nf, dt, wc; bit to;
        int consumed, g, pulses;
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h00; par_en = 1'b1;
        g = 0;
        while (txd !== 1'b0 && g < 100) begin @(negedge clk); g++; end
        bus.tx_valid = 1'b0;
        consumed = 0;
        while (consumed < 88 && g < 2000) begin
            if (tick16 === 1'b1) consumed++;
            @(negedge clk);
            g++;
        end
        tests_run++;
        if (consumed != 88 || txd !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_pre: ticks=%0d txd=%b busy=%b, required 88 0 1", consumed, txd, busy);
        end
        #2 areset = 1'b1;
        #1;
        tests_run++;
        if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_immediate: txd=%b ready=%b busy=%b, required 1 1 0", txd, bus.tx_ready, busy);
        end
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            if (done !== 1'b0 || fail !== 1'b0 || txd !== 1'b1) pulses++;
            @(negedge clk);
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: %0d cycles with done/fail/low txd, required 0", pulses);
        end
        bus.tx_valid = 1'b1; bus.tx_data = 8'hFF; par_en = 1'b1;
        watch_frame(1'b0, 1'b0, 8'h00, 1'b0, bits, nd, nf, dt, wc, to);
        tests_run++;
        if (to || bits !== 12'hDFE || nd !== 1 || nf !== 0) begin
            tests_failed++;
            $display("FAIL abort_next_ff: bits=%b done=%0d fail=%0d, required %b 1 0", bits, nd, nf, 12'hDFE);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] bits; int nd, nf, dt, wc; bit to;
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h11; par_en = 1'b1;
        watch_frame(1'b0, 1'b1, 8'h22, 1'b1, bits, nd, nf, dt, wc, to);
        tests_run++;
        if (to || bits !== 12'hC22 || nd !== 1 || wc !== 1) begin
            tests_failed++;
            $display("FAIL b2b_first: bits=%b done=%0d gap=%0d, required %b 1 1", bits, nd, wc, 12'hC22);
        end
        watch_frame(1'b0, 1'b0, 8'h00, 1'b1, bits, nd, nf, dt, wc, to);
        tests_run++;
        if (to || bits !== 12'hC44 || nd !== 1 || wc !== 1) begin
            tests_failed++;
            $display("FAIL b2b_second: bits=%b done=%0d gap=%0d, required %b 1 1", bits, nd, wc, 12'hC44);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.tx_ready !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_end: ready=%b busy=%b txd=%b, required 1 0 1", bus.tx_ready, busy, txd);
        end
    endtask

    initial begin
        areset = 1'b1; nack = 1'b0; par_en = 1'b0; tick16 = 1'b0; tick_en = 1'b1;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        test_reset();
        test_basic_frame();
        test_parity();
        test_retry_once();
        test_max_retry();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
